// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the two-requester UART TX arbiter.
package uart_arb_pkg;

  localparam int unsigned MAX_FRAME_BYTES_DEF = 64;
  localparam int unsigned CTS_SYNC_STAGES_DEF = 2;
  localparam int unsigned DATA_W              = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_STREAM = 1'b1
  } arb_state_e;

  // One requester byte as seen by the arbiter mux.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } req_beat_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and the TX-core byte stream of the arbiter.
interface uart_tx_arbiter_if;
  import uart_arb_pkg::*;

  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_last;
  logic              req0_ready;

  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_last;
  logic              req1_ready;

  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  // master: the arbiter itself; slave: requesters plus the TX core.
  modport master (
    input  req0_valid, req0_data, req0_last,
    output req0_ready,
    input  req1_valid, req1_data, req1_last,
    output req1_ready,
    output tx_valid, tx_data,
    input  tx_ready
  );

  modport slave (
    output req0_valid, req0_data, req0_last,
    input  req0_ready,
    output req1_valid, req1_data, req1_last,
    input  req1_ready,
    input  tx_valid, tx_data,
    output tx_ready
  );

endinterface

// File: rtl/uart_cts_sync.sv
// Multi-flop synchronizer for the asynchronous active-low CTS input.
module uart_cts_sync
  import uart_arb_pkg::*;
#(
  parameter int unsigned STAGES = CTS_SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic cts_n,
  output logic cts_ok
);

  logic [STAGES-1:0] sync_q;

  // Flops reset to 1 so the link starts out as not clear-to-send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], cts_n};
    end
  end

  assign cts_ok = ~sync_q[STAGES-1];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin frame arbiter between two byte requesters feeding one UART TX core.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = MAX_FRAME_BYTES_DEF,
  parameter int unsigned CTS_SYNC_STAGES = CTS_SYNC_STAGES_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst,
  uart_tx_arbiter_if.master                        bus,
  input  logic                                     uart_cts_n,
  output logic                                     grant_id,
  output logic                                     frame_active,
  output logic                                     frame_abort,
  output logic [$clog2(MAX_FRAME_BYTES+1)-1:0]     byte_count
);

  localparam int unsigned          CNT_W    = $clog2(MAX_FRAME_BYTES + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAX_FRAME_BYTES - 1);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              abort_q, abort_d;

  logic              cts_ok;
  logic              stream_ready;
  logic              sel_valid;
  req_beat_t         sel;
  logic              accept;

  uart_cts_sync #(
    .STAGES (CTS_SYNC_STAGES)
  ) u_cts_sync (
    .clk    (clk),
    .rst    (rst),
    .cts_n  (uart_cts_n),
    .cts_ok (cts_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
      count_q      <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      count_q      <= count_d;
      abort_q      <= abort_d;
    end
  end

  // Grant selection, frame tracking and output-register load/drain.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    tx_valid_d   = tx_valid_q;
    tx_data_d    = tx_data_q;
    count_d      = count_q;
    abort_d      = 1'b0;
    stream_ready = 1'b0;
    accept       = 1'b0;

    sel_valid = grant_q ? bus.req1_valid : bus.req0_valid;
    sel       = grant_q ? req_beat_t'{data: bus.req1_data, last: bus.req1_last}
                        : req_beat_t'{data: bus.req0_data, last: bus.req0_last};

    if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          grant_d = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
          count_d = '0;
          state_d = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        // CTS only gates new loads; a held byte still drains on tx_ready.
        stream_ready = cts_ok & (~tx_valid_q | bus.tx_ready);
        accept       = stream_ready & sel_valid;
        if (accept) begin
          tx_valid_d = 1'b1;
          tx_data_d  = sel.data;
          count_d    = count_q + CNT_W'(1);
          if (sel.last) begin
            state_d      = ARB_IDLE;
            last_grant_d = grant_q;
          end else if (count_q == CNT_LAST) begin
            abort_d      = 1'b1;
            state_d      = ARB_IDLE;
            last_grant_d = grant_q;
          end
        end
      end
    endcase
  end

  assign bus.req0_ready = stream_ready & ~grant_q;
  assign bus.req1_ready = stream_ready &  grant_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.tx_data    = tx_data_q;
  assign grant_id       = grant_q;
  assign frame_active   = (state_q == ARB_STREAM);
  assign frame_abort    = abort_q;
  assign byte_count     = count_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: directed frames with literal expectations plus randomized traffic vs a behavioural model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int unsigned MAXB = 4;
  localparam int unsigned STG  = 3;
  localparam int unsigned CW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          cts_n;
  logic          gid, fact, fab;
  logic [CW-1:0] bcnt;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(
    .MAX_FRAME_BYTES (MAXB),
    .CTS_SYNC_STAGES (STG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .uart_cts_n   (cts_n),
    .grant_id     (gid),
    .frame_active (fact),
    .frame_abort  (fab),
    .byte_count   (bcnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  req_beat_t  q0[$], q1[$];
  bit         hs0, hs1;
  int         acc0_cnt;
  logic [7:0] out_log[$];
  int         out_cyc[$];
  int         cyc;
  int         abort_seen;
  logic [7:0] exp_q[$];
  int         gap_pct, tr_mode, cts_mode;

  // Behavioural model state
  bit         m_stream, m_gid, m_last, m_txv, m_abort;
  logic [7:0] m_txd;
  int         m_cnt;
  bit         hist[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stream = 1'b0; m_gid = 1'b0; m_last = 1'b1; m_txv = 1'b0;
    m_txd = 8'h00; m_cnt = 0; m_abort = 1'b0;
    hist.delete();
    for (int i = 0; i < int'(STG); i++) hist.push_back(1'b1);
    exp_q.delete();
  endtask

  // Compare DUT against the model for this cycle, then advance the model over the coming edge.
  task automatic check_adv();
    bit cts_ok_m, rdy, v0, v1, sv, sl, acc;
    logic [7:0] sd;
    cts_ok_m = !hist[STG-1];
    rdy = m_stream && cts_ok_m && (!m_txv || bus.tx_ready);
    chk("req0_ready", 32'(bus.req0_ready), 32'(rdy && !m_gid));
    chk("req1_ready", 32'(bus.req1_ready), 32'(rdy && m_gid));
    chk("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
    if (m_txv) chk("tx_data", 32'(bus.tx_data), 32'(m_txd));
    chk("grant_id", 32'(gid), 32'(m_gid));
    chk("frame_active", 32'(fact), 32'(m_stream));
    chk("frame_abort", 32'(fab), 32'(m_abort));
    chk("byte_count", 32'(bcnt), 32'(m_cnt));

    if (bus.tx_valid && bus.tx_ready) begin
      out_log.push_back(bus.tx_data);
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("sb_spurious_byte", 32'(bus.tx_data), 32'hFFFF_FFFF);
      else chk("sb_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
    abort_seen += int'(fab);
    hs0 = bus.req0_valid && bus.req0_ready;
    hs1 = bus.req1_valid && bus.req1_ready;
    if (hs0) acc0_cnt++;

    v0 = bus.req0_valid; v1 = bus.req1_valid;
    sv = m_gid ? v1 : v0;
    sd = m_gid ? bus.req1_data : bus.req0_data;
    sl = m_gid ? bus.req1_last : bus.req0_last;
    acc = rdy && sv;
    m_abort = 1'b0;
    if (m_txv && bus.tx_ready) m_txv = 1'b0;
    if (acc) begin m_txv = 1'b1; m_txd = sd; exp_q.push_back(sd); end
    if (!m_stream) begin
      if (v0 || v1) begin
        m_gid = (v0 && v1) ? !m_last : v1;
        m_stream = 1'b1; m_cnt = 0;
      end
    end else if (acc) begin
      m_cnt++;
      if (sl || m_cnt == int'(MAXB)) begin
        m_stream = 1'b0; m_last = m_gid; m_abort = !sl;
      end
    end
    hist.push_front(cts_n);
    void'(hist.pop_back());
  endtask

  // Entered and left at posedge+1.
  task automatic step();
    if (hs0) void'(q0.pop_front());
    if (hs1) void'(q1.pop_front());
    hs0 = 1'b0; hs1 = 1'b0;
    bus.req0_valid = (q0.size() != 0) && ($urandom_range(99) >= 32'(gap_pct));
    bus.req0_data  = (q0.size() != 0) ? q0[0].data : 8'($urandom);
    bus.req0_last  = (q0.size() != 0) ? q0[0].last : 1'b0;
    bus.req1_valid = (q1.size() != 0) && ($urandom_range(99) >= 32'(gap_pct));
    bus.req1_data  = (q1.size() != 0) ? q1[0].data : 8'($urandom);
    bus.req1_last  = (q1.size() != 0) ? q1[0].last : 1'b0;
    case (tr_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = 1'($urandom_range(1));
      default: bus.tx_ready = ~bus.tx_ready;
    endcase
    if (cts_mode == 0) cts_n = 1'b0;
    else if ($urandom_range(15) == 0) cts_n = ~cts_n;
    #1;
    check_adv();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(bus.tx_valid), 0);
    chk("rst_tx_data", 32'(bus.tx_data), 0);
    chk("rst_req0_ready", 32'(bus.req0_ready), 0);
    chk("rst_req1_ready", 32'(bus.req1_ready), 0);
    chk("rst_grant_id", 32'(gid), 0);
    chk("rst_frame_active", 32'(fact), 0);
    chk("rst_frame_abort", 32'(fab), 0);
    chk("rst_byte_count", 32'(bcnt), 0);
    model_reset();
    q0.delete(); q1.delete();
    hs0 = 1'b0; hs1 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    out_log.delete(); out_cyc.delete(); abort_seen = 0; acc0_cnt = 0;
  endtask

  task automatic push_frame(input bit who, input int len);
    for (int i = 0; i < len; i++) begin
      if (who) q1.push_back(req_beat_t'{data: 8'($urandom), last: (i == len - 1)});
      else     q0.push_back(req_beat_t'{data: 8'($urandom), last: (i == len - 1)});
    end
  endtask

  task automatic chk_log(input string nm, input logic [7:0] exp[$]);
    chk({nm, "_len"}, 32'(out_log.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < out_log.size(); i++)
      chk(nm, 32'(out_log[i]), 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] e[$];
    rst = 1'b0; cts_n = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
    bus.tx_ready = 1'b1;
    gap_pct = 0; tr_mode = 0; cts_mode = 0; cyc = 0;
    hs0 = 1'b0; hs1 = 1'b0;
    @(posedge clk);
    #1;

    // Single two-byte frame
    do_reset(); clear_logs();
    q0.push_back(req_beat_t'{data: 8'hA5, last: 1'b0});
    q0.push_back(req_beat_t'{data: 8'h5A, last: 1'b1});
    run(20);
    e = '{8'hA5, 8'h5A};
    chk_log("a_bytes", e);
    if (out_cyc.size() == 2) chk("a_consecutive", 32'(out_cyc[1] - out_cyc[0]), 1);
    chk("a_byte_count", 32'(bcnt), 2);
    chk("a_idle", 32'(fact), 0);

    // Tie from reset: req0, req1, req0
    do_reset(); clear_logs();
    for (int i = 0; i < 3; i++) q0.push_back(req_beat_t'{data: 8'(8'h10 + i), last: (i == 2)});
    for (int i = 0; i < 3; i++) q1.push_back(req_beat_t'{data: 8'(8'h20 + i), last: (i == 2)});
    for (int i = 0; i < 3; i++) q0.push_back(req_beat_t'{data: 8'(8'h30 + i), last: (i == 2)});
    run(40);
    e = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32};
    chk_log("b_order", e);

    // Overlength frame on req1 aborts after MAXB bytes
    do_reset(); clear_logs();
    for (int i = 0; i < 6; i++) q1.push_back(req_beat_t'{data: 8'(8'h40 + i), last: 1'b0});
    run(40);
    e = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};
    chk_log("c_bytes", e);
    chk("c_abort_pulses", 32'(abort_seen), 1);
    chk("c_byte_count", 32'(bcnt), 2);
    chk("c_still_active", 32'(fact), 1);
    chk("c_grant", 32'(gid), 1);

    // Reset in the middle of a five-byte frame
    do_reset(); clear_logs();
    for (int i = 0; i < 5; i++) q0.push_back(req_beat_t'{data: 8'(8'h50 + i), last: (i == 4)});
    for (int i = 0; i < 60 && acc0_cnt < 2; i++) step();
    chk("d_two_accepted", 32'(acc0_cnt), 2);
    do_reset(); clear_logs();
    q0.push_back(req_beat_t'{data: 8'h60, last: 1'b0});
    q0.push_back(req_beat_t'{data: 8'h61, last: 1'b1});
    q1.push_back(req_beat_t'{data: 8'h70, last: 1'b0});
    q1.push_back(req_beat_t'{data: 8'h71, last: 1'b1});
    step();
    chk("d_tie_grant", 32'(gid), 0);
    chk("d_tie_active", 32'(fact), 1);
    run(25);
    e = '{8'h60, 8'h61, 8'h70, 8'h71};
    chk_log("d_bytes", e);

    // Randomized traffic with CTS flips, backpressure, gaps and resets
    do_reset(); clear_logs();
    cts_mode = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        gap_pct = int'($urandom_range(40));
        tr_mode = int'($urandom_range(2));
      end
      if (i == 1500 || i == 2800) do_reset();
      if (q0.size() < 4) push_frame(1'b0, int'($urandom_range(7, 1)));
      if (q1.size() < 4) push_frame(1'b1, int'($urandom_range(7, 1)));
      step();
    end
    cts_mode = 0; tr_mode = 0; gap_pct = 0;
    run(150);
    chk("f_drain_sb", 32'(exp_q.size()), 0);
    chk("f_drain_q0", 32'(q0.size()), 0);
    chk("f_drain_q1", 32'(q1.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
